// File: rtl/acq_pkg.sv
// Shared types and default widths for the acquisition controller.
// The ARM state exists only when ACQ_TRIGGER_EN is defined.
package acq_pkg;

  localparam int W        = 16;
  localparam int RATE_W   = 8;
  localparam int LEN_W    = 12;
  localparam int RATE_MIN = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
`ifdef ACQ_TRIGGER_EN
    S_ARM     = 3'd1,
`endif
    S_CAPTURE = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/acq_ctrl_decim_strobe.sv
// Phase counter for decimation: asserts keep on the valid sample whose phase is 0,
// then counts valid cycles modulo rate. rate is expected to be already normalised (>= 1).
module decim_strobe #(
  parameter int RATE_W = acq_pkg::RATE_W
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  input  logic              in_valid,
  output logic              keep
);
  import acq_pkg::*;

  logic [RATE_W-1:0] phase_q, phase_d;

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (in_valid) begin
      phase_d = (phase_q >= rate - 1'b1) ? '0 : phase_q + 1'b1;
    end
  end

  assign keep = in_valid && !clear && (phase_q == '0);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

endmodule

// File: rtl/acq_ctrl.sv
// Start/stop frame capture: decimates the sample stream by rate and emits frame_len slots
// with out_last and a done pulse. Define ACQ_TRIGGER_EN to add a level trigger (ARM state).
module acq_ctrl #(
  parameter int W      = acq_pkg::W,
  parameter int RATE_W = acq_pkg::RATE_W,
  parameter int LEN_W  = acq_pkg::LEN_W
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [RATE_W-1:0] rate,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
`ifdef ACQ_TRIGGER_EN
  input  logic signed [W-1:0] trig_level,
`endif
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);
  import acq_pkg::*;

  state_e            state_q, state_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  slot_q, slot_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              overrun_q, overrun_d;

  logic accept_start, strobe_valid, keep, final_slot, out_free;

`ifdef ACQ_TRIGGER_EN
  logic signed [W-1:0] prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic                crossing;

  assign crossing = in_valid && prev_valid_q && (prev_q < trig_level) &&
                    (trig_level <= $signed(in_data));
  assign strobe_valid = in_valid &&
                        ((state_q == S_CAPTURE) || ((state_q == S_ARM) && crossing));
`else
  assign strobe_valid = in_valid && (state_q == S_CAPTURE);
`endif

  assign accept_start = (state_q == S_IDLE) && start && !abort && (frame_len != '0);
  assign final_slot   = (slot_q == len_q - 1'b1);
  assign out_free     = !out_valid_q || out_ready;

  decim_strobe #(.RATE_W(RATE_W)) u_strobe (
    .in_clk   (in_clk),
    .rst      (rst),
    .clear    (accept_start),
    .rate     (rate_q),
    .in_valid (strobe_valid),
    .keep     (keep)
  );

  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    len_d       = len_q;
    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    overrun_d   = overrun_q;
`ifdef ACQ_TRIGGER_EN
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
`endif

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_start) begin
          rate_d    = (rate == '0) ? RATE_W'(RATE_MIN) : rate;
          len_d     = frame_len;
          slot_d    = '0;
          overrun_d = 1'b0;
`ifdef ACQ_TRIGGER_EN
          prev_valid_d = 1'b0;
          state_d      = S_ARM;
`else
          state_d   = S_CAPTURE;
`endif
        end
      end
`ifdef ACQ_TRIGGER_EN
      S_ARM: begin
        if (in_valid) begin
          prev_d       = $signed(in_data);
          prev_valid_d = 1'b1;
        end
        if (crossing) state_d = S_CAPTURE;
      end
`endif
      S_FLUSH: if (out_free) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase

    // A kept sample always consumes a slot, whether it reaches the output or is dropped.
    if (keep) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_last_d  = final_slot;
      end else begin
        overrun_d = 1'b1;
      end
      if (final_slot) state_d = S_FLUSH;
      else            slot_d  = slot_q + 1'b1;
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rate_q      <= RATE_W'(RATE_MIN);
      len_q       <= '0;
      slot_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ACQ_TRIGGER_EN
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      len_q       <= len_d;
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
`ifdef ACQ_TRIGGER_EN
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_acq_ctrl.sv
// Directed self-checking bench for acq_ctrl; the trigger scenario runs when ACQ_TRIGGER_EN is defined.
module tb_acq_ctrl;
  localparam int W = 16, RATE_W = 8, LEN_W = 12;

  logic              in_clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, abort = 1'b0;
  logic [RATE_W-1:0] rate = '0;
  logic [LEN_W-1:0]  frame_len = '0;
  logic              in_valid = 1'b0;
  logic [W-1:0]      in_data = '0;
  logic              out_valid, out_last, busy, done, overrun;
  logic [W-1:0]      out_data;
  logic              out_ready = 1'b1;
`ifdef ACQ_TRIGGER_EN
  logic signed [W-1:0] trig_level = 16'sd100;
`endif

  int tests = 0, fails = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, last_cyc = -1;
  logic [W-1:0] beat_q[$];
  logic         lastf_q[$];

  always #5 in_clk = ~in_clk;

  acq_ctrl #(.W(W), .RATE_W(RATE_W), .LEN_W(LEN_W)) dut (
    .in_clk    (in_clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .rate      (rate),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef ACQ_TRIGGER_EN
    .trig_level(trig_level),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  // Accepted beats and done pulses, sampled mid-cycle; a beat seen here handshakes at the next edge.
  always @(negedge in_clk) begin
    cyc++;
    if (out_valid && out_ready) begin
      beat_q.push_back(out_data);
      lastf_q.push_back(out_last);
      if (out_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_mon();
    beat_q.delete();
    lastf_q.delete();
    done_cnt = 0; done_cyc = -1; last_cyc = -1;
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge in_clk); #1; end
  endtask

  task automatic do_start(input int r, input int len);
    start = 1'b1; rate = RATE_W'(r); frame_len = LEN_W'(len);
    tick(1);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = W'(first + i);
      tick(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 50) begin tick(1); k++; end
    tests++;
    if (busy) begin fails++; $display("FAIL %s: busy still %0b after 50 cycles, want 0", name, busy); end
    tick(2);
  endtask

  task automatic check_frame(input string name, input int n, input int step, input int first,
                             input int want_last_idx);
    tests++;
    if (beat_q.size() != n) begin
      fails++; $display("FAIL %s beats: got %0d want %0d", name, beat_q.size(), n);
    end
    for (int i = 0; i < n && i < beat_q.size(); i++) begin
      tests++;
      if (beat_q[i] !== W'(first + step * i) || lastf_q[i] !== (i == want_last_idx)) begin
        fails++;
        $display("FAIL %s beat%0d: got data %0d last %0b want data %0d last %0b", name, i,
                 beat_q[i], lastf_q[i], first + step * i, i == want_last_idx);
      end
    end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL %s done count: got %0d want 1", name, done_cnt); end
  endtask

  task automatic test_reset();
    tick(2);
    tests++;
    if ({out_valid, out_data, out_last, busy, done, overrun} !== '0) begin
      fails++; $display("FAIL reset: got v%0b d%0d l%0b b%0b dn%0b o%0b want all 0",
                        out_valid, out_data, out_last, busy, done, overrun);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_decimate();
    clear_mon(); out_ready = 1'b1;
    do_start(3, 4);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL decim busy: got %0b want 1", busy); end
    feed(12, 0);
    wait_idle("decim");
    check_frame("decim", 4, 3, 0, 3);
    tests++;
    if (done_cyc != last_cyc + 1) begin
      fails++; $display("FAIL decim done timing: got cycle %0d want %0d", done_cyc, last_cyc + 1);
    end
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL decim overrun: got %0b want 0", overrun); end
  endtask

  task automatic test_rate_zero();
    clear_mon(); out_ready = 1'b1;
    do_start(0, 2);
    feed(4, 0);
    wait_idle("rate0");
    check_frame("rate0", 2, 1, 0, 1);
  endtask

  task automatic test_stall();
    clear_mon(); out_ready = 1'b0;
    do_start(1, 3);
    feed(3, 0);
    tick(5);
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'd0 || out_last !== 1'b0 ||
        overrun !== 1'b1 || done_cnt != 0) begin
      fails++; $display("FAIL stall hold: got b%0b v%0b d%0d l%0b o%0b dn%0d want b1 v1 d0 l0 o1 dn0",
                        busy, out_valid, out_data, out_last, overrun, done_cnt);
    end
    out_ready = 1'b1;
    wait_idle("stall");
    check_frame("stall", 1, 1, 0, -1);
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL stall sticky overrun: got %0b want 1", overrun); end
  endtask

  task automatic test_abort();
    clear_mon(); out_ready = 1'b0;
    do_start(1, 8);
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL abort start clears overrun: got %0b want 0", overrun); end
    feed(2, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b1) begin
      fails++; $display("FAIL abort: got b%0b v%0b o%0b want b0 v0 o1", busy, out_valid, overrun);
    end
    tick(4);
    tests++;
    if (done_cnt != 0) begin fails++; $display("FAIL abort done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_ignored_start();
    clear_mon(); out_ready = 1'b1;
    do_start(2, 0);
    tick(1);
    tests++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin
      fails++; $display("FAIL len0 start: got b%0b o%0b want b0 o1", busy, overrun);
    end
    abort = 1'b1;
    do_start(1, 3);
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL start+abort: got busy %0b want 0", busy); end
    do_start(1, 2);
    tests++;
    if (busy !== 1'b1 || overrun !== 1'b0) begin
      fails++; $display("FAIL restart: got b%0b o%0b want b1 o0", busy, overrun);
    end
    do_start(4, 5);
    feed(6, 0);
    wait_idle("busy start");
    check_frame("busy start", 2, 1, 0, 1);
  endtask

  task automatic test_reset_mid();
    clear_mon(); out_ready = 1'b0;
    do_start(1, 8);
    feed(2, 40);
    tests++;
    if (out_valid !== 1'b1 || overrun !== 1'b1) begin
      fails++; $display("FAIL pre-reset: got v%0b o%0b want v1 o1", out_valid, overrun);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, out_data, out_last, busy, done, overrun} !== '0) begin
      fails++; $display("FAIL mid reset: got v%0b d%0d l%0b b%0b dn%0b o%0b want all 0",
                        out_valid, out_data, out_last, busy, done, overrun);
    end
    tick(2);
    rst = 1'b0; out_ready = 1'b1;
    tick(3);
    tests++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL after reset: got done %0d busy %0b want 0 0", done_cnt, busy);
    end
  endtask

`ifdef ACQ_TRIGGER_EN
  task automatic test_trigger();
    logic [W-1:0] ramp [4];
    ramp = '{16'd90, 16'd95, 16'd105, 16'd110};
    clear_mon(); out_ready = 1'b1;
    do_start(1, 2);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = ramp[i];
      tick(1);
      if (i == 1) begin
        tests++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          fails++; $display("FAIL trig armed: got b%0b v%0b want b1 v0", busy, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    wait_idle("trigger");
    check_frame("trigger", 2, 5, 105, 1);
  endtask

  task automatic test_arm_reset();
    clear_mon();
    do_start(1, 4);
    feed(1, 90);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL arm busy: got %0b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, out_data, out_last, busy, done, overrun} !== '0) begin
      fails++; $display("FAIL arm reset: got v%0b d%0d l%0b b%0b dn%0b o%0b want all 0",
                        out_valid, out_data, out_last, busy, done, overrun);
    end
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask
`endif

  initial begin
    test_reset();
`ifdef ACQ_TRIGGER_EN
    test_trigger();
    test_arm_reset();
    test_reset_mid();
`else
    test_decimate();
    test_rate_zero();
    test_stall();
    test_abort();
    test_ignored_start();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
